rob_retire_ctrl: RTL
====================

# rob_retire_ctrl

In-order retirement controller that drives the remove and peek method ports of a 4-entry, 16-bit ring buffer. It inspects the buffer head every cycle and removes the head entry once its done flag is set. Each removed payload is handed downstream through a one-entry registered val/rdy output. It also supports a flush command that drains every buffered entry without retiring it, and it sits between the ring buffer and the commit/writeback consumer.

## Interface
- ENTRY_BITWIDTH, 16, width of a ring buffer entry
- DONE_BIT, 15, index of the done flag within an entry; payload is bits [DONE_BIT-1:0]
- CNT_NBITS, 8, width of the retire counter

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- peek_port_call  out  1  peek request to ring buffer
- peek_port_rdy  in  1  ring buffer non-empty
- peek_port_value  in  16  head entry; valid only while peek_port_call=1
- remove_port_call  out  1  remove head of ring buffer
- remove_port_rdy  in  1  ring buffer non-empty
- retire_val  out  1  retire_msg valid
- retire_rdy  in  1  downstream accepts retire_msg
- retire_msg  out  15  retired payload
- flush_call  in  1  request drain of ring buffer
- flush_rdy  out  1  flush may be accepted this cycle
- busy  out  1  state==FLUSH or retire_val=1
- retire_count  out  8  number of completed retire handshakes, mod 2^CNT_NBITS

## Operation
- States: RUN, FLUSH. Reset sets state RUN, out_val=0, out_msg=0, retire_count=0.
- retire_val=out_val. retire_msg=out_msg. flush_rdy=(state==RUN). busy=(state==FLUSH)|out_val.
- While reset=1, all call outputs are 0.
- RUN datapath:
  - peek_port_call=peek_port_rdy.
  - head_done=peek_port_rdy & peek_port_value[DONE_BIT].
  - space=!out_val | retire_rdy.
  - fire=head_done & space & !flush_call.
  - remove_port_call=fire.
- RUN, on fire: out_msg<=peek_port_value[14:0] and out_val<=1. If a retire handshake happens in the same cycle, the new entry replaces the old one with no bubble.
- RUN, handshake without fire: out_val<=0.
- Head present but not done: stall. No remove is issued; out_val drains normally.
- retire_count increments by 1 on every retire_val&retire_rdy cycle and wraps 255->0.
- Flush acceptance (flush_call & flush_rdy):
  - No remove is issued that cycle.
  - A retire handshake that completes in the same cycle still counts.
  - Next state is FLUSH, out_val<=0; a pending unaccepted output is discarded and not counted.
- FLUSH:
  - peek_port_call=0, retire_val=0.
  - remove_port_call=remove_port_rdy, issued every cycle regardless of done flag.
  - When remove_port_rdy=0 (buffer empty), next state is RUN.
  - flush_call is ignored because flush_rdy=0.
- Entries allocated into the buffer during FLUSH are also drained; FLUSH exits only on an observed empty cycle.
- Never assert remove_port_call when remove_port_rdy=0.
- Reset mid-flush or with a pending output returns to the reset state next cycle; the pending output is lost and the counter is cleared.

## Timing
- Remove decision is combinational from peek_port_value/peek_port_rdy/retire_rdy in the same cycle.
- Head removed in cycle N gives retire_val=1 in N+1.
- Throughput is 1 retire/cycle with retire_rdy held 1 and a done head present every cycle.
- retire_rdy=0 with out_val=1 blocks the next remove; the first remove occurs in the cycle retire_rdy returns to 1.
- Flush of k entries: accepted in cycle N, removes in N+1..N+k, RUN in N+k+2 (exit cycle N+k+1 observes empty).
- retire_count updates on the clock edge after the handshake.

## Test plan
- Reset, then alloc 0x8001, 0x8002, 0x8003 into the buffer with retire_rdy=1 -> retire_msg 0x0001, 0x0002, 0x0003 on consecutive cycles, retire_count=3.
- Head 0x0005 (not done), then update to 0x8005 three cycles later -> no remove while not done; removed the cycle after the update, retire_msg=0x0005.
- Four done entries with retire_rdy=0 for 5 cycles -> exactly one remove, retire_val held with msg stable; after retire_rdy=1, the remaining three retire back-to-back.
- Four entries (mixed done flags), out_val=1, flush_call pulse -> pending output dropped, retire_count unchanged, 4 consecutive removes, flush_rdy=1 again after the empty cycle, busy low.
- 256 retire handshakes -> retire_count wraps to 0; 257th -> 1.
- Assert reset during FLUSH with 2 entries left -> next cycle state RUN, out_val=0, count=0, no call outputs while reset is high.

Source files
------------

// File: rtl/rob_retire_ctrl.sv
// In-order retirement controller for a 4-entry ring buffer.
// Peeks the head every cycle and removes it once its done flag is set. The
// payload moves into a one-entry registered val/rdy output stage. A flush
// drains every buffered entry without retiring it, and counts as finished
// only when a cycle sees the buffer empty.
module rob_retire_ctrl #(
  parameter int ENTRY_BITWIDTH = 16,
  parameter int DONE_BIT       = 15,
  parameter int CNT_NBITS      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      peek_port_call,
  input  logic                      peek_port_rdy,
  input  logic [ENTRY_BITWIDTH-1:0] peek_port_value,
  output logic                      remove_port_call,
  input  logic                      remove_port_rdy,
  output logic                      retire_val,
  input  logic                      retire_rdy,
  output logic [DONE_BIT-1:0]       retire_msg,
  input  logic                      flush_call,
  output logic                      flush_rdy,
  output logic                      busy,
  output logic [CNT_NBITS-1:0]      retire_count
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic                 out_val;
  logic [DONE_BIT-1:0]  out_msg;
  logic                 head_done, space, fire, flush_acc, handshake;

  assign handshake  = out_val & retire_rdy;
  assign space      = !out_val | retire_rdy;
  assign retire_val = out_val;
  assign retire_msg = out_msg;
  assign flush_rdy  = (state == RUN);
  assign busy       = (state == FLUSH) | out_val;

  // Next state and port calls. The remove decision is combinational from the
  // current head and downstream ready, so back-to-back retires need no bubble.
  always_comb begin
    state_nxt        = state;
    peek_port_call   = 1'b0;
    remove_port_call = 1'b0;
    head_done        = 1'b0;
    fire             = 1'b0;
    flush_acc        = 1'b0;
    case (state)
      RUN: begin
        peek_port_call   = peek_port_rdy;
        head_done        = peek_port_rdy & peek_port_value[DONE_BIT];
        // A flush takes priority over a retire in the same cycle. Also gate
        // on remove_port_rdy so a remove never goes to an empty buffer.
        fire             = head_done & space & !flush_call & remove_port_rdy;
        remove_port_call = fire;
        flush_acc        = flush_call;
        if (flush_call) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Drain every entry whatever its done flag. Leave FLUSH only after
        // a cycle that sees the buffer empty, so entries allocated during
        // the drain are removed too.
        remove_port_call = remove_port_rdy;
        if (!remove_port_rdy) state_nxt = RUN;
      end
    endcase
    if (reset) begin
      peek_port_call   = 1'b0;
      remove_port_call = 1'b0;
      fire             = 1'b0;
      flush_acc        = 1'b0;
    end
  end

  // State register, output stage and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      out_val      <= 1'b0;
      out_msg      <= '0;
      retire_count <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) retire_count <= retire_count + CNT_NBITS'(1);
      if (flush_acc) begin
        // Drop any output that was not accepted this cycle.
        out_val <= 1'b0;
      end else if (fire) begin
        out_val <= 1'b1;
        out_msg <= peek_port_value[DONE_BIT-1:0];
      end else if (handshake) begin
        out_val <= 1'b0;
      end
    end
  end

endmodule
